// File: rtl/seven_seg_pkg.sv
// Shared segment patterns, error code and scan FSM states for the 7-segment
// display path; the encoder and this reader must agree on these bit-for-bit.
package seven_seg_pkg;

  // {a,b,c,d,e,f,g}, active-high
  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BCD_ERR   = 4'hF;

  typedef enum logic [0:0] {
    WAIT_STABLE = 1'b0,
    CAPTURED    = 1'b1
  } scan_state_e;

  function automatic logic [3:0] count_ones(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < 8; k++) begin
      n = n + {3'd0, v[k]};
    end
    return n;
  endfunction

endpackage

// File: rtl/seven_seg_scan_reader_if.sv
// Scanned display bus in, recovered frame out. The display driver side is the
// master; the scan reader is the slave.
interface seven_seg_scan_reader_if #(
  parameter int NUM_DIGITS = 4
) ();

  logic [NUM_DIGITS-1:0]   dig_sel;
  logic [6:0]              segments;
  logic [4*NUM_DIGITS-1:0] frame_value;
  logic                    frame_valid;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    pattern_err;
  logic                    sel_err;

  modport master (
    output dig_sel, segments,
    input  frame_value, frame_valid, digit_valid, pattern_err, sel_err
  );

  modport slave (
    input  dig_sel, segments,
    output frame_value, frame_valid, digit_valid, pattern_err, sel_err
  );

endinterface

// File: rtl/seg_pattern_decode.sv
// Combinational inverse of the segment encoder: exact pattern match only,
// anything outside the ten digit codes and blank is reported as invalid.
module seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] i_segments,
  output logic       o_valid,
  output logic       o_is_blank,
  output logic [3:0] o_bcd
);

  // pattern lookup
  always_comb begin
    o_valid    = 1'b1;
    o_is_blank = 1'b0;
    o_bcd      = BCD_ERR;
    case (i_segments)
      SEG_0:     o_bcd = 4'd0;
      SEG_1:     o_bcd = 4'd1;
      SEG_2:     o_bcd = 4'd2;
      SEG_3:     o_bcd = 4'd3;
      SEG_4:     o_bcd = 4'd4;
      SEG_5:     o_bcd = 4'd5;
      SEG_6:     o_bcd = 4'd6;
      SEG_7:     o_bcd = 4'd7;
      SEG_8:     o_bcd = 4'd8;
      SEG_9:     o_bcd = 4'd9;
      SEG_BLANK: begin
        o_valid    = 1'b0;
        o_is_blank = 1'b1;
      end
      default:   o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_reader.sv
// Loopback reader for a scanned 7-segment bus: waits for each {dig_sel,segments}
// pair to settle, decodes it once, and emits a frame when every digit was seen.
module seven_seg_scan_reader
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  input logic                    clear,
  seven_seg_scan_reader_if.slave bus
);

  localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NUM_DIGITS-1:0]   r_sel_s1, r_sel_s2, r_sel_prev;
  logic [6:0]              r_seg_s1, r_seg_s2, r_seg_prev;
  logic [CNT_W-1:0]        r_cnt;
  scan_state_e             r_state;
  logic [4*NUM_DIGITS-1:0] r_digits, r_frame_value;
  logic [NUM_DIGITS-1:0]   r_digit_valid, r_seen;
  logic                    r_frame_valid, r_pattern_err, r_sel_err;

  logic                    w_change, w_eval;
  logic [CNT_W-1:0]        w_cnt_next;
  scan_state_e             w_state_next;
  logic                    w_seg_valid, w_seg_blank;
  logic [3:0]              w_seg_bcd, w_pop;
  logic [4*NUM_DIGITS-1:0] w_digits_next, w_fv_next;
  logic [NUM_DIGITS-1:0]   w_dv_next, w_seen_next;
  logic                    w_fvalid_next, w_perr_next, w_serr_next;

  seg_pattern_decode u_decode (
    .i_segments (r_seg_s2),
    .o_valid    (w_seg_valid),
    .o_is_blank (w_seg_blank),
    .o_bcd      (w_seg_bcd)
  );

  assign w_pop = count_ones(8'(r_sel_s2));

  // Evaluation fires on the edge where the count reaches STABLE_CYCLES, so a
  // pair first sampled at edge t is captured at edge t+1+STABLE_CYCLES.
  always_comb begin
    w_change     = ({r_sel_s2, r_seg_s2} != {r_sel_prev, r_seg_prev});
    w_eval       = 1'b0;
    w_state_next = r_state;
    if (w_change) begin
      w_cnt_next = CNT_ONE;
    end else if (r_cnt == CNT_MAX) begin
      w_cnt_next = r_cnt;
    end else begin
      w_cnt_next = r_cnt + CNT_ONE;
    end
    case (r_state)
      WAIT_STABLE: begin
        if (w_cnt_next == CNT_MAX) begin
          w_eval       = 1'b1;
          w_state_next = CAPTURED;
        end else begin
          w_state_next = WAIT_STABLE;
        end
      end
      CAPTURED: begin
        if (w_change && (w_cnt_next == CNT_MAX)) begin
          w_eval       = 1'b1;
          w_state_next = CAPTURED;
        end else if (w_change) begin
          w_state_next = WAIT_STABLE;
        end else begin
          w_state_next = CAPTURED;
        end
      end
      default: w_state_next = WAIT_STABLE;
    endcase
  end

  // Digit update and frame completion; the completing digit is included in the frame.
  always_comb begin
    w_digits_next = r_digits;
    w_dv_next     = r_digit_valid;
    w_seen_next   = r_seen;
    w_perr_next   = r_pattern_err;
    w_serr_next   = r_sel_err;
    w_fv_next     = r_frame_value;
    w_fvalid_next = 1'b0;
    if (w_eval && (w_pop > 4'd1)) begin
      w_serr_next = 1'b1;
    end else if (w_eval && (w_pop == 4'd1) && !w_seg_blank) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (r_sel_s2[i]) begin
          w_digits_next[4*i +: 4] = w_seg_valid ? w_seg_bcd : BCD_ERR;
          w_dv_next[i]            = w_seg_valid;
          w_seen_next[i]          = 1'b1;
        end else begin
          w_seen_next[i]          = r_seen[i];
        end
      end
      w_perr_next = r_pattern_err | ~w_seg_valid;
      if (&w_seen_next) begin
        w_fv_next     = w_digits_next;
        w_fvalid_next = 1'b1;
        w_seen_next   = {NUM_DIGITS{1'b0}};
      end else begin
        w_fvalid_next = 1'b0;
      end
    end else begin
      w_fvalid_next = 1'b0;
    end
  end

  // Synchronisers, stability tracking and all captured state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_s1 <= {NUM_DIGITS{1'b0}};  r_sel_s2 <= {NUM_DIGITS{1'b0}};
      r_sel_prev <= {NUM_DIGITS{1'b0}};
      r_seg_s1 <= 7'h00;  r_seg_s2 <= 7'h00;  r_seg_prev <= 7'h00;
      r_cnt <= {CNT_W{1'b0}};
      r_state <= WAIT_STABLE;
      r_digits <= {4*NUM_DIGITS{1'b0}};  r_frame_value <= {4*NUM_DIGITS{1'b0}};
      r_digit_valid <= {NUM_DIGITS{1'b0}};  r_seen <= {NUM_DIGITS{1'b0}};
      r_frame_valid <= 1'b0;  r_pattern_err <= 1'b0;  r_sel_err <= 1'b0;
    end else if (clear) begin
      r_sel_s1 <= {NUM_DIGITS{1'b0}};  r_sel_s2 <= {NUM_DIGITS{1'b0}};
      r_sel_prev <= {NUM_DIGITS{1'b0}};
      r_seg_s1 <= 7'h00;  r_seg_s2 <= 7'h00;  r_seg_prev <= 7'h00;
      r_cnt <= {CNT_W{1'b0}};
      r_state <= WAIT_STABLE;
      r_digits <= {4*NUM_DIGITS{1'b0}};  r_frame_value <= {4*NUM_DIGITS{1'b0}};
      r_digit_valid <= {NUM_DIGITS{1'b0}};  r_seen <= {NUM_DIGITS{1'b0}};
      r_frame_valid <= 1'b0;  r_pattern_err <= 1'b0;  r_sel_err <= 1'b0;
    end else begin
      r_sel_s1 <= bus.dig_sel;  r_sel_s2 <= r_sel_s1;  r_sel_prev <= r_sel_s2;
      r_seg_s1 <= bus.segments; r_seg_s2 <= r_seg_s1; r_seg_prev <= r_seg_s2;
      r_cnt <= w_cnt_next;
      r_state <= w_state_next;
      r_digits <= w_digits_next;  r_frame_value <= w_fv_next;
      r_digit_valid <= w_dv_next;  r_seen <= w_seen_next;
      r_frame_valid <= w_fvalid_next;  r_pattern_err <= w_perr_next;
      r_sel_err <= w_serr_next;
    end
  end

  assign bus.frame_value = r_frame_value;
  assign bus.frame_valid = r_frame_valid;
  assign bus.digit_valid = r_digit_valid;
  assign bus.pattern_err = r_pattern_err;
  assign bus.sel_err     = r_sel_err;

endmodule

// File: tb/tb_seven_seg_scan_reader.sv
// Bench for seven_seg_scan_reader: directed scans plus random traffic, checked
// against a run-length reference model with a queue of expected frames.
module tb_seven_seg_scan_reader;

  localparam int N = 4;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  seven_seg_scan_reader_if #(.NUM_DIGITS(N)) bus ();

  seven_seg_scan_reader #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  logic [6:0] segtab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                              7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  int n_checks = 0;
  int n_errors = 0;
  int frames_seen = 0;
  logic [4*N-1:0] last_frame = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int             due;
    logic [N-1:0]   sel;
    logic [6:0]     seg;
  } pend_t;

  int             m_dig [N];
  logic [N-1:0]   m_dv, m_seen;
  logic           m_perr, m_serr;
  logic [4*N-1:0] m_fv;
  logic [4*N-1:0] exp_q [$];
  pend_t          pend_q [$];
  int             cyc = 0;
  int             run_len;
  logic [N-1:0]   run_sel;
  logic [6:0]     run_seg;

  task automatic m_reset();
    for (int j = 0; j < N; j++) m_dig[j] = 0;
    m_dv = '0; m_seen = '0; m_perr = 1'b0; m_serr = 1'b0; m_fv = '0;
    pend_q.delete();
    run_len = 0; run_sel = '0; run_seg = '0;
  endtask

  task automatic m_eval(input logic [N-1:0] s, input logic [6:0] g);
    int v;
    int idx;
    logic [4*N-1:0] f;
    v = -1;
    idx = 0;
    for (int k = 0; k < 10; k++) if (segtab[k] == g) v = k;
    if (s == '0) return;
    if ($countones(s) > 1) begin
      m_serr = 1'b1;
      return;
    end
    if (g == 7'h00) return;
    for (int j = 0; j < N; j++) if (s[j]) idx = j;
    if (v < 0) begin
      m_dig[idx] = 15; m_dv[idx] = 1'b0; m_perr = 1'b1;
    end else begin
      m_dig[idx] = v;  m_dv[idx] = 1'b1;
    end
    m_seen[idx] = 1'b1;
    if (m_seen == {N{1'b1}}) begin
      f = '0;
      for (int j = 0; j < N; j++) f[4*j +: 4] = 4'(m_dig[j]);
      m_fv = f;
      exp_q.push_back(f);
      m_seen = '0;
    end
  endtask

  // A pair held for S consecutive samples starting at edge t is decoded at edge t+S+1.
  initial begin
    m_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n || clear) begin
        m_reset();
      end else begin
        while (pend_q.size() > 0 && pend_q[0].due == cyc) begin
          m_eval(pend_q[0].sel, pend_q[0].seg);
          void'(pend_q.pop_front());
        end
        if (run_len > 0 && bus.dig_sel == run_sel && bus.segments == run_seg) begin
          run_len++;
        end else begin
          run_len = 1; run_sel = bus.dig_sel; run_seg = bus.segments;
        end
        if (run_len == S) pend_q.push_back('{cyc + 2, run_sel, run_seg});
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [4*N-1:0] mon_exp;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.frame_valid) begin
          frames_seen++;
          last_frame = bus.frame_value;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_frame: got frame_valid=1 value %0h, expected no frame (t=%0t)",
                     bus.frame_value, $time);
          end else begin
            mon_exp = exp_q.pop_front();
            check("frame_value", 32'(bus.frame_value), 32'(mon_exp));
          end
        end
        check("frame_hold",  32'(bus.frame_value), 32'(m_fv));
        check("digit_valid", 32'(bus.digit_valid), 32'(m_dv));
        check("pattern_err", 32'(bus.pattern_err), 32'(m_perr));
        check("sel_err",     32'(bus.sel_err),     32'(m_serr));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic hold(input logic [N-1:0] s, input logic [6:0] g, input int n);
    bus.dig_sel  = s;
    bus.segments = g;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_frame_value"}, 32'(bus.frame_value), 32'h0);
    check({tag, "_frame_valid"}, 32'(bus.frame_valid), 32'h0);
    check({tag, "_digit_valid"}, 32'(bus.digit_valid), 32'h0);
    check({tag, "_pattern_err"}, 32'(bus.pattern_err), 32'h0);
    check({tag, "_sel_err"},     32'(bus.sel_err),     32'h0);
  endtask

  int f0;
  logic [N-1:0] rs;
  logic [6:0]   rg;
  int           r;

  initial begin
    bus.dig_sel  = 4'b0001;
    bus.segments = 7'h30;
    repeat (5) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    hold(4'b0000, 7'h00, 20);
    check("idle_no_frame", 32'(frames_seen), 32'd0);

    // frame 1-2-3-4
    f0 = frames_seen;
    hold(4'b0001, 7'h30, 8); hold(4'b0010, 7'h6D, 8);
    hold(4'b0100, 7'h79, 8); hold(4'b1000, 7'h33, 8);
    hold(4'b0000, 7'h00, 4);
    check("f1234_count", 32'(frames_seen - f0), 32'd1);
    check("f1234_value", 32'(last_frame), 32'h4321);
    check("f1234_dv", 32'(bus.digit_valid), 32'hF);
    check("f1234_errs", {30'd0, bus.pattern_err, bus.sel_err}, 32'd0);

    // glitching digit 0, then a stable 5
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    hold(4'b0001, 7'h30, 3); hold(4'b0001, 7'h6D, 3);
    hold(4'b0001, 7'h79, 3); hold(4'b0001, 7'h33, 3);
    check("glitch_no_capture", 32'(bus.digit_valid), 32'h0);
    hold(4'b0001, 7'h5B, 6);
    check("glitch_then_hold", 32'(bus.digit_valid), 32'h1);
    hold(4'b0010, 7'h5F, 8); hold(4'b0100, 7'h70, 8); hold(4'b1000, 7'h7F, 8);
    hold(4'b0000, 7'h00, 4);
    check("f5678_value", 32'(last_frame), 32'h8765);

    // illegal pattern on digit 2, then a clean frame
    hold(4'b0001, 7'h7E, 8); hold(4'b0010, 7'h7B, 8);
    hold(4'b0100, 7'h01, 8); hold(4'b1000, 7'h30, 8);
    hold(4'b0000, 7'h00, 4);
    check("illegal_value", 32'(last_frame), 32'h1F90);
    check("illegal_dv", 32'(bus.digit_valid), 32'hB);
    check("illegal_perr", 32'(bus.pattern_err), 32'h1);
    hold(4'b0001, 7'h6D, 8); hold(4'b0010, 7'h79, 8);
    hold(4'b0100, 7'h33, 8); hold(4'b1000, 7'h5B, 8);
    hold(4'b0000, 7'h00, 4);
    check("clean_value", 32'(last_frame), 32'h5432);
    check("perr_sticky", 32'(bus.pattern_err), 32'h1);

    // multi-hot select, blank digit
    f0 = frames_seen;
    hold(4'b0011, 7'h30, 10);
    check("multihot_serr", 32'(bus.sel_err), 32'h1);
    check("multihot_dv", 32'(bus.digit_valid), 32'hF);
    hold(4'b0001, 7'h79, 8); hold(4'b0010, 7'h00, 8);
    hold(4'b0100, 7'h33, 8); hold(4'b1000, 7'h5B, 8);
    hold(4'b0000, 7'h00, 4);
    check("blank_no_frame", 32'(frames_seen - f0), 32'd0);
    hold(4'b0010, 7'h5F, 8); hold(4'b0000, 7'h00, 4);
    check("blank_then_frame", 32'(last_frame), 32'h5463);

    // repeated digit 0, then clear and reset mid-frame
    hold(4'b0001, 7'h5B, 8); hold(4'b0001, 7'h7B, 8);
    hold(4'b0010, 7'h30, 8); hold(4'b0100, 7'h6D, 8); hold(4'b1000, 7'h79, 8);
    hold(4'b0000, 7'h00, 4);
    check("repeat_value", 32'(last_frame), 32'h3219);
    f0 = frames_seen;
    hold(4'b0001, 7'h33, 8); hold(4'b0010, 7'h33, 8);
    bus.dig_sel = '0; bus.segments = '0; clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    check_all_zero("clear");
    hold(4'b0001, 7'h30, 8); hold(4'b0010, 7'h30, 8);
    bus.dig_sel = '0; bus.segments = '0; rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    rst_n = 1'b1;
    hold(4'b0000, 7'h00, 10);
    check("discard_no_frame", 32'(frames_seen - f0), 32'd0);

    // random traffic
    repeat (400) begin
      r = $urandom_range(0, 9);
      if (r == 0)      rs = '0;
      else if (r == 1) rs = N'($urandom);
      else begin
        rs = '0;
        rs[$urandom_range(0, N-1)] = 1'b1;
      end
      r = $urandom_range(0, 9);
      if (r == 0)      rg = 7'h00;
      else if (r == 1) rg = 7'($urandom);
      else             rg = segtab[$urandom_range(0, 9)];
      hold(rs, rg, $urandom_range(1, 8));
      if ($urandom_range(0, 59) == 0) begin
        clear = 1'b1; @(negedge clk); clear = 1'b0;
      end
    end
    hold(4'b0000, 7'h00, 10);
    check("frames_pending", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
